datapath_mux_arb: RTL
=====================

Name: datapath_mux_arb

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with per-channel valid/ready handshakes and a registered output stage.
- Selection mode is fixed-priority, round-robin or explicit select.
- Feeds shared datapath resources such as the ALU operand and register write-back paths, where several producers contend for one consumer.
- Generalises the fixed 4:1 combinational select: adds arbitration, back-pressure and one-cycle registered latency.

Parameters:
- WIDTH, 8, data width per channel (>=1).
- CHANNELS, 4, number of input channels (2..16).
- SEL_WIDTH, 2, select/index width; must equal ceil(log2(CHANNELS)).
- MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round-robin, 2 = explicit select via sel.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_data, input, CHANNELS*WIDTH, channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid, input, CHANNELS, per-channel request/valid.
- in_ready, output, CHANNELS, per-channel accept; combinational.
- sel, input, SEL_WIDTH, channel index; used only when MODE=2.
- out_data, output, WIDTH, registered selected data.
- out_chan, output, SEL_WIDTH, registered index of the channel that supplied out_data.
- out_valid, output, 1, output register holds valid data.
- out_ready, input, 1, consumer accept.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_chan=0, round-robin pointer=0 (channel 0 highest). Reset mid-transfer discards held data; in_ready is all zeros while rst_n is low.
- Load enable: load_ok = !out_valid || out_ready. Full throughput: one transfer per cycle when out_ready is held high.
- Grant, one-hot, combinational from in_valid:
  - MODE 0: lowest-index valid channel.
  - MODE 1: first valid channel searching upward from pointer p, wrapping CHANNELS-1 -> 0.
  - MODE 2: channel sel, granted only if in_valid[sel]=1. If sel >= CHANNELS (non-power-of-two CHANNELS), no grant.
- in_ready[i] = grant[i] && load_ok. At most one in_ready bit is high in any cycle.
- Transfer on channel i when in_valid[i] && in_ready[i]. Next edge: out_data <= in_data[i], out_chan <= i, out_valid <= 1. Latency is exactly 1 cycle from input handshake to out_valid.
- No grant and out_ready=1 while out_valid=1: out_valid <= 0. out_data and out_chan hold their last values.
- Back-pressure: while out_valid && !out_ready, out_data, out_chan and out_valid are stable, and all in_ready are 0.
- Simultaneous out_ready and new grant: output drains and reloads in the same edge, with no bubble.
- Round-robin pointer:
  - Updates only on a completed input transfer: p <= (i+1) mod CHANNELS. Wraps from CHANNELS-1 to 0.
  - Unchanged when there is no transfer, including stalled cycles.
  - Unused in MODE 0 and MODE 2; held at 0.
- Inputs: the block requires no stability rule on inputs without a transfer. A producer may drop in_valid before it is granted.
- out_valid depends only on registered state; no combinational path from out_ready to out_valid.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0 and out_chan=0 immediately (asynchronous, before any clock edge). First grant after release is channel 0 in MODE 1.
- Round-robin fairness (MODE 1, CHANNELS=4, WIDTH=8): in_valid=4'b1111, in_data={8'h44,8'h33,8'h22,8'h11}, out_ready=1. Expect out_chan sequence 0,1,2,3,0 and out_data 11,22,33,44,11, one per cycle after 1-cycle latency.
- Fixed priority (MODE 0): in_valid=4'b1010 -> in_ready=4'b0010 and out_chan=1 every cycle. Channel 3 is starved until in_valid[1]=0, then out_chan=3.
- Back-pressure: out_ready=0 for 3 cycles after out_data=8'h22 loads. Expect out_data=8'h22 and out_valid=1 stable, and in_ready=0 for all 3 cycles. Raise out_ready: 8'h22 drains and the next grant loads on the same edge.
- Explicit select (MODE 2, CHANNELS=3, SEL_WIDTH=2): sel=2 with in_valid=3'b100 -> out_chan=2 after 1 cycle. sel=3 -> in_ready=0 and out_valid falls to 0 once drained.
- Wrap and idle (MODE 1): single transfer on channel 3 -> pointer=0. All inputs idle for 5 cycles -> pointer stays 0, out_valid=0 after drain.

Source files
------------

// File: rtl/datapath_mux_arb_if.sv
// Bundle of the per-channel input handshakes, the explicit select and the registered output
// handshake shared by the producers, the arbiter and the consumer.
interface datapath_mux_arb_if #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned SEL_WIDTH = 2
);
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic [SEL_WIDTH-1:0]      sel;
   logic [WIDTH-1:0]          out_data;
   logic [SEL_WIDTH-1:0]      out_chan;
   logic                      out_valid;
   logic                      out_ready;

   modport master (
      output in_data, in_valid, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  in_data, in_valid, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/datapath_mux_arb.sv
// N-channel valid/ready multiplexer with fixed-priority, round-robin or explicit-select
// arbitration feeding a single registered output stage.
module datapath_mux_arb #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned SEL_WIDTH = 2,
   parameter int unsigned MODE      = 1
) (
   input logic                clk,
   input logic                rst_n,
   datapath_mux_arb_if.slave  bus
);
   logic [WIDTH-1:0]     r_out_data;
   logic [SEL_WIDTH-1:0] r_out_chan;
   logic                 r_out_valid;
   logic [SEL_WIDTH-1:0] r_ptr;

   logic                 w_load_ok;
   logic                 w_hit;
   logic                 w_xfer;
   logic [SEL_WIDTH-1:0] w_gidx;
   logic [CHANNELS-1:0]  w_grant;
   logic [WIDTH-1:0]     w_sel_data;
   int unsigned          w_best;
   int unsigned          w_dist;

   assign w_load_ok = !r_out_valid || bus.out_ready;

   // Round-robin picks the valid channel at the smallest upward distance from the pointer.
   always_comb begin
      w_hit  = 1'b0;
      w_gidx = '0;
      w_best = CHANNELS;
      w_dist = 0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (MODE == 0) begin
            if (!w_hit && bus.in_valid[i]) begin
               w_hit  = 1'b1;
               w_gidx = SEL_WIDTH'(i);
            end
         end else if (MODE == 1) begin
            w_dist = (i + CHANNELS - 32'(r_ptr)) % CHANNELS;
            if (bus.in_valid[i] && (w_dist < w_best)) begin
               w_best = w_dist;
               w_hit  = 1'b1;
               w_gidx = SEL_WIDTH'(i);
            end
         end else begin
            if ((32'(bus.sel) == i) && bus.in_valid[i]) begin
               w_hit  = 1'b1;
               w_gidx = SEL_WIDTH'(i);
            end
         end
      end
   end

   always_comb begin
      w_grant    = '0;
      w_sel_data = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (w_hit && (w_gidx == SEL_WIDTH'(i))) begin
            w_grant[i] = 1'b1;
            w_sel_data = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign w_xfer       = w_hit && w_load_ok;
   assign bus.in_ready = rst_n ? (w_grant & {CHANNELS{w_load_ok}}) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_chan  <= '0;
         r_out_valid <= 1'b0;
         r_ptr       <= '0;
      end else if (w_xfer) begin
         r_out_data  <= w_sel_data;
         r_out_chan  <= w_gidx;
         r_out_valid <= 1'b1;
         if (MODE == 1) begin
            r_ptr <= (w_gidx == SEL_WIDTH'(CHANNELS - 1)) ? '0 : w_gidx + 1'b1;
         end
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.out_data  = r_out_data;
   assign bus.out_chan  = r_out_chan;
   assign bus.out_valid = r_out_valid;
endmodule
